// File: rtl/fpu_pkg.sv
// Shared single-precision FP definitions: field layout, special encodings,
// the multiplier sequencer states and the operand classification record.
package fpu_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_SIGN_W   = 1;
  localparam int FP_EXP_W    = 8;
  localparam int FP_FRAC_W   = 23;
  localparam int FP_SIG_W    = FP_FRAC_W + 1;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fsm_state_e;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_SIG_W-1:0] sig;
    logic                is_zero;
    logic                is_inf;
    logic                is_nan;
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Decodes one IEEE-754 single operand; denormals are flushed to signed zero,
// so any operand with a zero exponent reports is_zero.
module fp_classify
  import fpu_pkg::*;
(
  input  logic [31:0] op,
  output fp_class_t   cls
);

  logic [FP_EXP_W-1:0]  exp_f;
  logic [FP_FRAC_W-1:0] frac_f;

  assign exp_f  = op[30:23];
  assign frac_f = op[22:0];

  always_comb begin
    cls.sign    = op[31];
    cls.exp     = exp_f;
    cls.sig     = {1'b1, frac_f};
    cls.is_zero = (exp_f == '0);
    cls.is_inf  = (exp_f == '1) && (frac_f == '0);
    cls.is_nan  = (exp_f == '1) && (frac_f != '0);
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential single-precision multiplier: shift-add over the 24-bit significand,
// BITS_PER_CYCLE multiplier bits per MUL cycle, one-cycle normalize/pack, truncating.
module fp_mul_seq
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  localparam int MUL_CYCLES = FP_SIG_W / BITS_PER_CYCLE;

  fp_class_t cls_a, cls_b;

  fp_classify u_cls_a (.op(op_a), .cls(cls_a));
  fp_classify u_cls_b (.op(op_b), .cls(cls_b));

  fsm_state_e        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic [4:0]        rd_tag_q, rd_tag_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [47:0]       acc_q, acc_d;
  logic [47:0]       mcand_q, mcand_d;
  logic [23:0]       mplier_q, mplier_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic              special_q, special_d;
  logic [31:0]       special_res_q, special_res_d;

  logic              sign_in;
  logic              any_nan, any_inf, any_zero;
  logic [47:0]       partial;
  logic signed [9:0] exp_fin;
  logic [22:0]       frac_fin;

  // Special-operand decode for the operands currently on the read buses.
  always_comb begin
    sign_in  = cls_a.sign ^ cls_b.sign;
    any_nan  = cls_a.is_nan | cls_b.is_nan
             | (cls_a.is_inf & cls_b.is_zero) | (cls_a.is_zero & cls_b.is_inf);
    any_inf  = cls_a.is_inf | cls_b.is_inf;
    any_zero = cls_a.is_zero | cls_b.is_zero;
  end

  // NOTE: every always_comb output is defaulted first so no path can hold a
  // value and infer a latch.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = done_q;
    result_d      = result_q;
    rd_out_d      = rd_out_q;
    rd_tag_d      = rd_tag_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    sign_d        = sign_q;
    exp_d         = exp_q;
    special_d     = special_q;
    special_res_d = special_res_q;
    partial       = '0;
    exp_fin       = exp_q + $signed({9'b0, acc_q[47]});
    frac_fin      = acc_q[47] ? acc_q[46:24] : acc_q[45:23];

    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = MUL;
          busy_d    = 1'b1;
          rd_tag_d  = rd_in;
          cnt_d     = '0;
          acc_d     = '0;
          mcand_d   = {24'b0, cls_a.sig};
          mplier_d  = cls_b.sig;
          sign_d    = sign_in;
          exp_d     = $signed({2'b00, cls_a.exp}) + $signed({2'b00, cls_b.exp})
                    - 10'(FP_EXP_BIAS);
          special_d = any_nan | any_inf | any_zero;
          if (any_nan)      special_res_d = FP_QNAN;
          else if (any_inf) special_res_d = {sign_in, FP_INF[30:0]};
          else              special_res_d = {sign_in, 31'b0};
        end
      end
      MUL: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'(MUL_CYCLES - 1)) begin
          state_d = NORM;
          cnt_d   = '0;
        end
      end
      NORM: begin
        state_d  = DONE;
        done_d   = 1'b1;
        rd_out_d = rd_tag_q;
        if (special_q)                result_d = special_res_q;
        else if (exp_fin >= 10'sd255) result_d = {sign_q, FP_INF[30:0]};
        else if (exp_fin <= 10'sd0)   result_d = {sign_q, 31'b0};
        else                          result_d = {sign_q, exp_fin[7:0], frac_fin};
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      rd_out_q      <= '0;
      rd_tag_q      <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      special_q     <= 1'b0;
      special_res_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      rd_out_q      <= rd_out_d;
      rd_tag_q      <= rd_tag_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      sign_q        <= sign_d;
      exp_q         <= exp_d;
      special_q     <= special_d;
      special_res_q <= special_res_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: a vector table of hand-computed products plus
// sequences for latency, busy-ignore, back-to-back, mid-MUL reset and BITS_PER_CYCLE=4.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start4;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, busy4, done4;
  logic [31:0] result, result4;
  logic [4:0]  rd_out, rd_out4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_mul_seq #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  fp_mul_seq #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .busy(busy4), .done(done4), .result(result4), .rd_out(rd_out4)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one operation; cyc is the cycle number in which done was seen
  // (start sampled in cycle 0), -1 on timeout.
  task automatic run_op(input bit use4, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res,
                        output logic [4:0] rdo, output int cyc,
                        output logic done_after, output logic busy_after);
    bit got = 0;
    @(negedge clk);
    op_a = a; op_b = b; rd_in = rd;
    if (use4) start4 = 1'b1; else start = 1'b1;
    cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; start4 = 1'b0;
      if (use4 ? done4 : done) got = 1;
    end
    if (!got) cyc = -1;
    res = use4 ? result4 : result;
    rdo = use4 ? rd_out4 : rd_out;
    @(negedge clk);
    done_after = use4 ? done4 : done;
    busy_after = use4 ? busy4 : busy;
  endtask

  initial begin
    logic [31:0] res;
    logic [4:0]  rdo;
    int          cyc;
    logic        d_after, b_after;
    int          done_cycles[$];
    bit          got;

    vecs.push_back('{"basic_2x3",     32'h4000_0000, 32'h4040_0000, 5'd5,  32'h40C0_0000});
    vecs.push_back('{"norm_1p5sq",    32'h3FC0_0000, 32'h3FC0_0000, 5'd1,  32'h4010_0000});
    vecs.push_back('{"neg_sign",      32'hC000_0000, 32'h4040_0000, 5'd2,  32'hC0C0_0000});
    vecs.push_back('{"overflow",      32'h7F00_0000, 32'h4000_0000, 5'd3,  32'h7F80_0000});
    vecs.push_back('{"underflow",     32'h0080_0000, 32'h3F00_0000, 5'd4,  32'h0000_0000});
    vecs.push_back('{"inf_x_zero",    32'h7F80_0000, 32'h0000_0000, 5'd6,  32'h7FC0_0000});
    vecs.push_back('{"ninf_x_two",    32'hFF80_0000, 32'h4000_0000, 5'd7,  32'hFF80_0000});
    vecs.push_back('{"nan_x_one",     32'h7F80_0001, 32'h3F80_0000, 5'd8,  32'h7FC0_0000});
    vecs.push_back('{"nzero_x_two",   32'h8000_0000, 32'h4000_0000, 5'd9,  32'h8000_0000});
    vecs.push_back('{"denorm_flush",  32'h0040_0000, 32'hC000_0000, 5'd10, 32'h8000_0000});
    vecs.push_back('{"neg_x_neg",     32'hBFC0_0000, 32'hC000_0000, 5'd31, 32'h4040_0000});

    reset = 1'b1; start = 1'b0; start4 = 1'b0;
    op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_result", result,      32'd0);
    check("reset_rd_out", 32'(rd_out), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].rd, res, rdo, cyc, d_after, b_after);
      check({vecs[i].name, "_latency"}, 32'(cyc), 32'd26);
      check({vecs[i].name, "_result"},  res, vecs[i].exp_res);
      check({vecs[i].name, "_rd_out"},  32'(rdo), 32'(vecs[i].rd));
      check({vecs[i].name, "_done_pulse"}, 32'(d_after), 32'd0);
      check({vecs[i].name, "_busy_after"}, 32'(b_after), 32'd0);
    end

    // start with other operands while busy (MUL through DONE) must be ignored.
    @(negedge clk);
    op_a = 32'h4000_0000; op_b = 32'h4040_0000; rd_in = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; got = 0;
    while (!got && cyc < 100) begin
      if (cyc == 5) begin
        op_a = 32'h3F80_0000; op_b = 32'h3F80_0000; rd_in = 5'd9; start = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (done) begin got = 1; start = 1'b0; end
    end
    check("ignore_latency", 32'(cyc), 32'd26);
    check("ignore_result",  result, 32'h40C0_0000);
    check("ignore_rd_out",  32'(rd_out), 32'd7);
    repeat (2) @(negedge clk);
    check("ignore_done_state_start", 32'(busy), 32'd0);

    // start held high: one done every 27 cycles.
    @(negedge clk);
    op_a = 32'h4000_0000; op_b = 32'h4040_0000; rd_in = 5'd5; start = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (done) done_cycles.push_back(c);
    end
    start = 1'b0;
    check("b2b_count", 32'(done_cycles.size()), 32'd3);
    for (int k = 0; k < done_cycles.size() && k < 3; k++)
      check($sformatf("b2b_done_%0d", k), 32'(done_cycles[k]), 32'(26 + 27 * k));
    got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    check("b2b_drain", 32'(got), 32'd1);

    // reset during MUL cycle 10: outputs clear, no done afterwards.
    @(negedge clk);
    op_a = 32'h4000_0000; op_b = 32'h4040_0000; rd_in = 5'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy",   32'(busy),   32'd0);
    check("rst_mid_done",   32'(done),   32'd0);
    check("rst_mid_result", result,      32'd0);
    check("rst_mid_rd_out", 32'(rd_out), 32'd0);
    got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) got = 1;
    end
    check("rst_mid_no_done", 32'(got), 32'd0);

    // BITS_PER_CYCLE=4 instance: same product in 8 cycles.
    run_op(1'b1, 32'h4000_0000, 32'h4040_0000, 5'd5, res, rdo, cyc, d_after, b_after);
    check("bpc4_latency", 32'(cyc), 32'd8);
    check("bpc4_result",  res, 32'h40C0_0000);
    check("bpc4_rd_out",  32'(rdo), 32'd5);
    check("bpc4_busy_after", 32'(b_after), 32'd0);
    run_op(1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 5'd3, res, rdo, cyc, d_after, b_after);
    check("bpc4_norm_result", res, 32'h4010_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
